iorq_chan_fsm: RTL and testbench

- Multi-channel successor to the single-channel phi-domain IORQ tick generator.
- Synchronises a qualified Z8S180 I/O request (IOC=1 timing) through a parametrised shift register and detects its leading edge.
- Steers a one-phi-period read or write tick to one of CHANNELS peripheral slots.
- Optionally holds WAIT_n low for a fixed number of phi periods first, so slow FPGA peripherals can be serviced.

---
 rtl/iorq_chan_fsm.sv | 124 ++++++++++++
 tb/tb_iorq_chan_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/iorq_chan_fsm.sv
// Multi-channel phi-domain IORQ tick generator: synchronises a qualified I/O request,
// optionally stretches WAIT_n, then steers a one-phi rd/wr tick to the selected slot.
// Optional abort counter enabled by defining IORQ_ABORT_COUNT_EN.
module iorq_chan_fsm #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_DEPTH  = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic                phi,
    input  logic                reset_n,
    input  logic                iorq_n,
    input  logic                rd_n,
    input  logic                wr_n,
    input  logic [CHANNELS-1:0] sel,
    output logic [CHANNELS-1:0] rd_tick,
    output logic [CHANNELS-1:0] wr_tick,
    output logic                wait_n,
    output logic                busy,
    output logic [7:0]          abort_cnt
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, TICK, HOLD} state_t;

    state_t                state_q, state_d;
    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [CH_W-1:0]       ch_q, ch_d, sel_idx;
    logic                  dir_q, dir_d;   // 1 = read
    logic                  req, start;

    assign req   = ~iorq_n & (~rd_n | ~wr_n) & (|sel);
    assign start = (&sync_q[SYNC_DEPTH-2:0]) & ~sync_q[SYNC_DEPTH-1] & req;

    // Descending scan so the lowest set bit of sel wins.
    always_comb begin
        sel_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (sel[i]) sel_idx = CH_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        dir_d   = dir_q;
        sync_d  = {sync_q[SYNC_DEPTH-2:0], req};
        case (state_q)
            IDLE: begin
                if (start) begin
                    ch_d  = sel_idx;
                    dir_d = ~rd_n;
                    if (WAIT_STATES == 0) begin
                        state_d = TICK;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!req)             state_d = IDLE;
                else if (cnt_q == '0) state_d = TICK;
                else                  cnt_d   = cnt_q - 4'd1;
            end
            TICK:    state_d = HOLD;
            HOLD:    if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge phi) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sync_q  <= '0;
            cnt_q   <= '0;
            ch_q    <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        rd_tick = '0;
        wr_tick = '0;
        if (state_q == TICK && req) begin
            if (dir_q) rd_tick[ch_q] = 1'b1;
            else       wr_tick[ch_q] = 1'b1;
        end
    end

    assign wait_n = (state_q != WAIT);
    assign busy   = (state_q != IDLE);

`ifdef IORQ_ABORT_COUNT_EN
    logic       abort;
    logic [7:0] abort_cnt_q, abort_cnt_d;

    // Request dropped while stretching, or gone by the tick period.
    assign abort = ((state_q == WAIT) | (state_q == TICK)) & ~req;

    always_comb begin
        abort_cnt_d = abort_cnt_q;
        if (abort && abort_cnt_q != 8'hFF) abort_cnt_d = abort_cnt_q + 8'd1;
    end

    always_ff @(posedge phi) begin
        if (!reset_n) abort_cnt_q <= 8'h00;
        else          abort_cnt_q <= abort_cnt_d;
    end

    assign abort_cnt = abort_cnt_q;
`else
    assign abort_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_iorq_chan_fsm.sv
// Bench for iorq_chan_fsm: three configurations driven in parallel, checked against a
// transaction-level model, a directed vector table and hand-written corner sequences.
module tb_iorq_chan_fsm;

    logic       phi = 1'b0;
    logic       reset_n, iorq_n, rd_n, wr_n;
    logic [3:0] sel;
    logic [3:0] rd_t[3], wr_t[3];
    logic       wn[3], bz[3];
    logic [7:0] ac[3];

    int errors = 0;
    int checks = 0;

`ifdef IORQ_ABORT_COUNT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    always #5 phi = ~phi;

    iorq_chan_fsm #(.CHANNELS(4), .SYNC_DEPTH(2), .WAIT_STATES(0)) u_d0 (
        .phi(phi), .reset_n(reset_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .sel(sel),
        .rd_tick(rd_t[0]), .wr_tick(wr_t[0]), .wait_n(wn[0]), .busy(bz[0]), .abort_cnt(ac[0]));
    iorq_chan_fsm #(.CHANNELS(4), .SYNC_DEPTH(2), .WAIT_STATES(3)) u_d1 (
        .phi(phi), .reset_n(reset_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .sel(sel),
        .rd_tick(rd_t[1]), .wr_tick(wr_t[1]), .wait_n(wn[1]), .busy(bz[1]), .abort_cnt(ac[1]));
    iorq_chan_fsm #(.CHANNELS(4), .SYNC_DEPTH(3), .WAIT_STATES(2)) u_d2 (
        .phi(phi), .reset_n(reset_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .sel(sel),
        .rd_tick(rd_t[2]), .wr_tick(wr_t[2]), .wait_n(wn[2]), .busy(bz[2]), .abort_cnt(ac[2]));

    // Reference model: a transaction record aged in phi periods since its start.
    int       ws_m[3] = '{0, 3, 2};
    int       sd_m[3] = '{2, 2, 3};
    bit [7:0] hist[3];
    bit       act_m[3], hold_m[3], rdd_m[3];
    int       el_m[3], ch_m[3], ab_m[3];

    // Output samples taken mid-period by step().
    logic [3:0] sr[3], sw[3];
    logic       sn[3], sb[3];
    logic [7:0] sa[3];

    typedef struct {
        bit         io, rd, wr;
        logic [3:0] sel, erd, ewr;
        bit         ewn, ebz;
    } vec_t;
    vec_t vt[21];

    function automatic int lowest(input logic [3:0] s);
        for (int k = 0; k < 4; k++) if (s[k]) return k;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic step(input bit r, input bit io, input bit rd, input bit wr, input logic [3:0] s);
        bit         req, tickp, waitp, start;
        logic [3:0] erd, ewr;
        reset_n = r; iorq_n = io; rd_n = rd; wr_n = wr; sel = s;
        @(negedge phi);
        req = !io && (!rd || !wr) && (s != 4'h0);
        for (int i = 0; i < 3; i++) begin
            sr[i] = rd_t[i]; sw[i] = wr_t[i]; sn[i] = wn[i]; sb[i] = bz[i]; sa[i] = ac[i];
            tickp = act_m[i] && !hold_m[i] && el_m[i] == ws_m[i];
            waitp = act_m[i] && !hold_m[i] && el_m[i] < ws_m[i];
            erd = (tickp && req && rdd_m[i])  ? 4'(1 << ch_m[i]) : 4'h0;
            ewr = (tickp && req && !rdd_m[i]) ? 4'(1 << ch_m[i]) : 4'h0;
            chk($sformatf("model_dut%0d", i), {rd_t[i], wr_t[i], wn[i], bz[i], ac[i]},
                {erd, ewr, !waitp, act_m[i], (ABORT_EN ? 8'(ab_m[i]) : 8'h00)});
        end
        @(posedge phi);
        for (int i = 0; i < 3; i++) begin
            if (!r) begin
                hist[i] = '0; act_m[i] = 0; hold_m[i] = 0; el_m[i] = 0;
                ch_m[i] = 0; rdd_m[i] = 0; ab_m[i] = 0;
            end else begin
                start = req && !hist[i][sd_m[i]-1];
                for (int k = 0; k < sd_m[i] - 1; k++) if (!hist[i][k]) start = 0;
                if (!act_m[i]) begin
                    if (start) begin
                        act_m[i] = 1; hold_m[i] = 0; el_m[i] = 0;
                        ch_m[i] = lowest(s); rdd_m[i] = !rd;
                    end
                end else if (hold_m[i]) begin
                    if (!req) act_m[i] = 0;
                end else if (el_m[i] < ws_m[i]) begin
                    if (!req) begin
                        act_m[i] = 0;
                        if (ab_m[i] < 255) ab_m[i]++;
                    end else el_m[i]++;
                end else begin
                    hold_m[i] = 1;
                    if (!req && ab_m[i] < 255) ab_m[i]++;
                end
                hist[i] = {hist[i][6:0], req};
            end
        end
        #1;
    endtask

    initial begin
        int n;
        logic [3:0] seen;
        reset_n = 0; iorq_n = 1; rd_n = 1; wr_n = 1; sel = 4'h0;
        @(posedge phi); #1;
        step(0, 1, 1, 1, 4'h0);
        chk("reset_state", {sr[0], sw[0], sn[0], sb[0], sa[0]}, {4'h0, 4'h0, 1'b1, 1'b0, 8'h00});

        // Directed table for the WS=0, SYNC_DEPTH=2 instance.
        vt[0]  = '{1, 1, 1, 4'h0, 4'h0, 4'h0, 1, 0};
        vt[1]  = '{0, 0, 1, 4'h4, 4'h0, 4'h0, 1, 0};
        vt[2]  = '{0, 0, 1, 4'h4, 4'h0, 4'h0, 1, 0};
        vt[3]  = '{0, 0, 1, 4'h4, 4'h4, 4'h0, 1, 1};
        vt[4]  = '{0, 0, 1, 4'h4, 4'h0, 4'h0, 1, 1};
        vt[5]  = '{1, 1, 1, 4'h4, 4'h0, 4'h0, 1, 1};
        vt[6]  = '{1, 1, 1, 4'h0, 4'h0, 4'h0, 1, 0};
        vt[7]  = '{0, 0, 0, 4'hA, 4'h0, 4'h0, 1, 0};
        vt[8]  = '{0, 0, 0, 4'hA, 4'h0, 4'h0, 1, 0};
        vt[9]  = '{0, 0, 0, 4'h8, 4'h2, 4'h0, 1, 1};
        vt[10] = '{0, 0, 0, 4'h8, 4'h0, 4'h0, 1, 1};
        vt[11] = '{1, 1, 1, 4'h0, 4'h0, 4'h0, 1, 1};
        vt[12] = '{1, 1, 1, 4'h0, 4'h0, 4'h0, 1, 0};
        vt[13] = '{0, 0, 1, 4'h0, 4'h0, 4'h0, 1, 0};
        vt[14] = '{0, 0, 1, 4'h0, 4'h0, 4'h0, 1, 0};
        vt[15] = '{0, 0, 1, 4'h0, 4'h0, 4'h0, 1, 0};
        vt[16] = '{0, 1, 0, 4'h1, 4'h0, 4'h0, 1, 0};
        vt[17] = '{0, 1, 0, 4'h1, 4'h0, 4'h0, 1, 0};
        vt[18] = '{0, 1, 0, 4'h1, 4'h0, 4'h1, 1, 1};
        vt[19] = '{1, 1, 1, 4'h0, 4'h0, 4'h0, 1, 1};
        vt[20] = '{1, 1, 1, 4'h0, 4'h0, 4'h0, 1, 0};
        for (int k = 0; k < 21; k++) begin
            step(1, vt[k].io, vt[k].rd, vt[k].wr, vt[k].sel);
            chk($sformatf("tbl%0d", k), {sr[0], sw[0], sn[0], sb[0]},
                {vt[k].erd, vt[k].ewr, vt[k].ewn, vt[k].ebz});
        end

        // WAIT_STATES=3 write: three wait periods, then one tick, busy through HOLD.
        for (int c = 0; c < 10; c++) begin
            step(1, c > 7, 1, c > 7, 4'h1);
            chk($sformatf("ws3_c%0d", c), {sw[1], sr[1], sn[1], sb[1]},
                {(c == 5 ? 4'h1 : 4'h0), 4'h0, !(c >= 2 && c <= 4), (c >= 2 && c <= 8)});
        end

        // Reset pulse while in WAIT abandons the transaction.
        step(1, 0, 0, 1, 4'h4);
        step(1, 0, 0, 1, 4'h4);
        step(1, 0, 0, 1, 4'h4);
        step(0, 0, 0, 1, 4'h4);
        step(1, 1, 1, 1, 4'h0);
        chk("post_reset", {sr[1], sw[1], sn[1], sb[1], sa[1]}, {4'h0, 4'h0, 1'b1, 1'b0, 8'h00});
        n = 0; seen = 4'h0;
        for (int c = 0; c < 11; c++) begin
            step(1, c > 8, c > 8, 1, 4'h4);
            if (sr[1] != 4'h0) begin n++; seen = sr[1]; end
        end
        chk("clean_after_reset_cnt", n, 1);
        chk("clean_after_reset_ch", seen, 4'h4);

        // Request released after the first wait period.
        step(1, 0, 1, 0, 4'h1);
        step(1, 0, 1, 0, 4'h1);
        step(1, 0, 1, 0, 4'h1);
        step(1, 1, 1, 1, 4'h1);
        chk("abort_in_wait", sn[1], 1'b0);
        step(1, 1, 1, 1, 4'h0);
        chk("abort_idle", {sr[1], sw[1], sn[1], sb[1]}, {4'h0, 4'h0, 1'b1, 1'b0});
        chk("abort_cnt_one", sa[1], ABORT_EN ? 8'h01 : 8'h00);

        // SYNC_DEPTH=3: single-period glitch, then a held request.
        n = 0;
        for (int c = 0; c < 5; c++) begin
            step(1, c != 0, 0, 1, 4'h2);
            if (sr[2] != 4'h0 || sw[2] != 4'h0) n++;
        end
        chk("glitch_no_tick", n, 0);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step(1, c > 7, 0, 1, 4'h2);
            if (sr[2] != 4'h0 || sw[2] != 4'h0) n++;
        end
        chk("held_one_tick", n, 1);

        // 300 aborts saturate the counter.
        for (int a = 0; a < 300; a++) begin
            step(1, 0, 0, 1, 4'h8);
            step(1, 0, 0, 1, 4'h8);
            step(1, 1, 1, 1, 4'h8);
            step(1, 1, 1, 1, 4'h8);
        end
        chk("sat_dut0", sa[0], ABORT_EN ? 8'hFF : 8'h00);
        chk("sat_dut1", sa[1], ABORT_EN ? 8'hFF : 8'h00);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; ) begin
            bit         io, rd, wr, r;
            logic [3:0] s;
            int         len;
            io  = ($urandom_range(3) == 0);
            rd  = $urandom_range(1);
            wr  = $urandom_range(1);
            case ($urandom_range(3))
                0:       s = 4'h0;
                1, 2:    s = 4'(1 << $urandom_range(3));
                default: s = 4'($urandom);
            endcase
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                r = ($urandom_range(149) != 0);
                step(r, io, rd, wr, s);
                c++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
